// File: rtl/mem_c_tile_writer.sv
// rtl/mem_c_tile_writer.sv - drains result-FIFO beats into strided C-tile memory writes
// Optional feature macro: CFG_EDGE_MASK_EN (partial edge tiles with byte-masked strobes)
module mem_c_tile_writer #(
  parameter int BUS_WIDTH_BYTES  = 32,
  parameter int DATA_WIDTH_BYTES = 2,
  parameter int ARRAY_HEIGHT     = 4,
  parameter int ARRAY_WIDTH      = 32,
  parameter int ADDR_WIDTH       = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start_i,
  input  logic                       abort_i,
  input  logic [15:0]                m_i,
  input  logic [15:0]                p_i,
  input  logic [15:0]                ld_c_i,
  input  logic [ADDR_WIDTH-1:0]      base_addr_c_i,
  input  logic                       fifo_empty_i,
  output logic                       fifo_pop_o,
  output logic                       wr_valid_o,
  input  logic                       wr_ready_i,
  output logic [ADDR_WIDTH-1:0]      wr_addr_o,
  output logic [BUS_WIDTH_BYTES-1:0] wr_strb_o,
  output logic                       busy_o,
  output logic                       tile_done_o,
  output logic                       op_done_o,
  output logic                       cfg_err_o
);

  localparam int EPB = BUS_WIDTH_BYTES / DATA_WIDTH_BYTES;
  localparam int BPR = ARRAY_WIDTH / EPB;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [31:0] base_q;
  logic [15:0] m_q, p_q, ld_q, tr_last_q, tc_last_q;
  logic [15:0] tr_q, tc_q, r_q, b_q;
  logic [15:0] tr_n, tc_n, r_n, b_n;
  logic        in_range_q;
  logic        cfg_zero, cfg_legal, start_ok, load, tile_end, op_end;

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input logic [15:0] ld,
                                            input logic [15:0] tr, input logic [15:0] tc,
                                            input logic [15:0] r, input logic [15:0] b);
    logic [31:0] row, col;
    row = 32'(tr) * ARRAY_HEIGHT + 32'(r);
    col = 32'(tc) * ARRAY_WIDTH + 32'(b) * EPB;
    return base + (row * 32'(ld) + col) * DATA_WIDTH_BYTES;
  endfunction

  function automatic logic beat_in_range(input logic [15:0] m, input logic [15:0] p,
                                         input logic [15:0] tr, input logic [15:0] tc,
                                         input logic [15:0] r, input logic [15:0] b);
    logic [31:0] row, col;
    row = 32'(tr) * ARRAY_HEIGHT + 32'(r);
    col = 32'(tc) * ARRAY_WIDTH + 32'(b) * EPB;
    return (row < 32'(m)) && (col < 32'(p));
  endfunction

`ifdef CFG_EDGE_MASK_EN
  // Enable only the element lanes whose column falls inside the C matrix.
  function automatic logic [BUS_WIDTH_BYTES-1:0] edge_strb(input logic [15:0] p,
                                                           input logic [15:0] tc,
                                                           input logic [15:0] b);
    logic [BUS_WIDTH_BYTES-1:0] s;
    logic [31:0]                col;
    s   = '0;
    col = 32'(tc) * ARRAY_WIDTH + 32'(b) * EPB;
    for (int e = 0; e < EPB; e++)
      if (col + 32'(e) < 32'(p)) s[e*DATA_WIDTH_BYTES +: DATA_WIDTH_BYTES] = '1;
    return s;
  endfunction
  assign cfg_legal = 1'b1;
`else
  assign cfg_legal = ((32'(m_i) % 32'(ARRAY_HEIGHT)) == 32'd0) &&
                     ((32'(p_i) % 32'(ARRAY_WIDTH)) == 32'd0);
`endif

  assign cfg_zero = (m_i == 16'd0) || (p_i == 16'd0);
  assign start_ok = (state_q == IDLE) && start_i && !abort_i;
  assign load     = start_ok && !cfg_zero && cfg_legal;
  assign tile_end = (r_q == 16'(ARRAY_HEIGHT - 1)) && (b_q == 16'(BPR - 1));
  assign op_end   = tile_end && (tc_q == tc_last_q) && (tr_q == tr_last_q);

  // Beat handshake: writes go out only for in-range beats; out-of-range beats are drained.
  always_comb begin
    wr_valid_o  = 1'b0;
    fifo_pop_o  = 1'b0;
    if (state_q == RUN && !abort_i) begin
      wr_valid_o = in_range_q && !fifo_empty_i;
      fifo_pop_o = in_range_q ? (!fifo_empty_i && wr_ready_i) : !fifo_empty_i;
    end
    tile_done_o = fifo_pop_o && tile_end;
    op_done_o   = (state_q == DONE) && !abort_i;
    busy_o      = (state_q != IDLE);
  end

  // Next beat position: row fastest, then beat within the row, then tile column, then tile row.
  always_comb begin
    tr_n = tr_q;
    tc_n = tc_q;
    r_n  = r_q + 16'd1;
    b_n  = b_q;
    if (r_q == 16'(ARRAY_HEIGHT - 1)) begin
      r_n = '0;
      if (b_q == 16'(BPR - 1)) begin
        b_n = '0;
        if (tc_q == tc_last_q) begin
          tc_n = '0;
          tr_n = tr_q + 16'd1;
        end else begin
          tc_n = tc_q + 16'd1;
        end
      end else begin
        b_n = b_q + 16'd1;
      end
    end
  end

  // Next-state logic; abort wins over everything including a simultaneous start.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start_i && cfg_zero) state_d = DONE;
                 else if (load)           state_d = RUN;
        RUN:     if (fifo_pop_o && op_end) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Config capture, beat counters and the registered address/strobe of the presented beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0; m_q <= '0; p_q <= '0; ld_q <= '0; tr_last_q <= '0; tc_last_q <= '0;
      tr_q <= '0; tc_q <= '0; r_q <= '0; b_q <= '0;
      in_range_q <= 1'b0; wr_addr_o <= '0; wr_strb_o <= '0; cfg_err_o <= 1'b0;
    end else begin
      cfg_err_o <= start_ok && !cfg_zero && !cfg_legal;
      if (abort_i) begin
        tr_q <= '0; tc_q <= '0; r_q <= '0; b_q <= '0;
        in_range_q <= 1'b0; wr_addr_o <= '0; wr_strb_o <= '0;
      end else if (load) begin
        base_q     <= 32'(base_addr_c_i);
        m_q        <= m_i;
        p_q        <= p_i;
        ld_q       <= ld_c_i;
        tr_last_q  <= 16'((32'(m_i) - 32'd1) / 32'(ARRAY_HEIGHT));
        tc_last_q  <= 16'((32'(p_i) - 32'd1) / 32'(ARRAY_WIDTH));
        tr_q <= '0; tc_q <= '0; r_q <= '0; b_q <= '0;
        in_range_q <= 1'b1;
        wr_addr_o  <= ADDR_WIDTH'(32'(base_addr_c_i));
`ifdef CFG_EDGE_MASK_EN
        wr_strb_o  <= edge_strb(p_i, 16'd0, 16'd0);
`else
        wr_strb_o  <= '1;
`endif
      end else if (fifo_pop_o && !op_end) begin
        tr_q <= tr_n; tc_q <= tc_n; r_q <= r_n; b_q <= b_n;
        in_range_q <= beat_in_range(m_q, p_q, tr_n, tc_n, r_n, b_n);
        wr_addr_o  <= ADDR_WIDTH'(beat_addr(base_q, ld_q, tr_n, tc_n, r_n, b_n));
`ifdef CFG_EDGE_MASK_EN
        wr_strb_o  <= edge_strb(p_q, tc_n, b_n);
`else
        wr_strb_o  <= '1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_c_tile_writer.sv
// tb/tb_mem_c_tile_writer.sv - self-checking bench for mem_c_tile_writer
module tb_mem_c_tile_writer;

  localparam int H = 4, W = 32, DWB = 2, EPB = 16, BPR = 2;

  logic        clk = 0, reset_n = 0, start_i = 0, abort_i = 0;
  logic        fifo_empty_i = 1, wr_ready_i = 0;
  logic [15:0] m_i = 0, p_i = 0, ld_c_i = 0;
  logic [31:0] base_addr_c_i = 0;
  logic        fifo_pop_o, wr_valid_o, busy_o, tile_done_o, op_done_o, cfg_err_o;
  logic [31:0] wr_addr_o, wr_strb_o;

  int n_vec = 0, n_err = 0;

  typedef struct {logic [31:0] addr; logic [31:0] strb; bit wr; bit tl;} beat_t;
  beat_t exp_q[$];

  mem_c_tile_writer dut (
    .clk(clk), .reset_n(reset_n), .start_i(start_i), .abort_i(abort_i),
    .m_i(m_i), .p_i(p_i), .ld_c_i(ld_c_i), .base_addr_c_i(base_addr_c_i),
    .fifo_empty_i(fifo_empty_i), .fifo_pop_o(fifo_pop_o), .wr_valid_o(wr_valid_o),
    .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o), .wr_strb_o(wr_strb_o),
    .busy_o(busy_o), .tile_done_o(tile_done_o), .op_done_o(op_done_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  // Reference: every beat of the operation in visiting order, straight from the tiling rules.
  function automatic void build_exp(input int m, input int p, input int ld, input logic [31:0] base);
    exp_q.delete();
    for (int tr = 0; tr < (m + H - 1) / H; tr++)
      for (int tc = 0; tc < (p + W - 1) / W; tc++)
        for (int b = 0; b < BPR; b++)
          for (int r = 0; r < H; r++) begin
            beat_t bt;
            int row;
            int col;
            row = tr * H + r;
            col = tc * W + b * EPB;
            bt.wr   = (row < m) && (col < p);
            bt.addr = base + 32'((row * ld + col) * DWB);
            bt.strb = '1;
`ifdef CFG_EDGE_MASK_EN
            for (int e = 0; e < EPB; e++) if (col + e >= p) bt.strb[e*DWB +: DWB] = '0;
`endif
            bt.tl = (r == H - 1) && (b == BPR - 1);
            exp_q.push_back(bt);
          end
  endfunction

  task automatic start_op(input int m, input int p, input int ld, input logic [31:0] base);
    @(negedge clk);
    m_i = 16'(m); p_i = 16'(p); ld_c_i = 16'(ld); base_addr_c_i = base; start_i = 1;
    #1;
  endtask

  task automatic test_reset;
    reset_n = 0;
    #2;
    n_vec++; if ({busy_o, wr_valid_o, fifo_pop_o, tile_done_o, op_done_o, cfg_err_o} !== 6'b0) begin n_err++; $display("FAIL reset_ctrl: got %b want 000000", {busy_o, wr_valid_o, fifo_pop_o, tile_done_o, op_done_o, cfg_err_o}); end
    n_vec++; if (wr_addr_o !== 32'h0 || wr_strb_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got addr %h strb %h want 0 0", wr_addr_o, wr_strb_o); end
    @(negedge clk); reset_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [31:0] ea [8];
    ea = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0, 32'h1020, 32'h1060, 32'h10A0, 32'h10E0};
    fifo_empty_i = 0; wr_ready_i = 1;
    start_op(4, 32, 32, 32'h1000);
    @(negedge clk); start_i = 0; #1;
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (wr_valid_o !== 1'b1 || fifo_pop_o !== 1'b1 || wr_addr_o !== ea[i]) begin n_err++; $display("FAIL basic_beat%0d: got v=%b pop=%b addr=%h want 1 1 %h", i, wr_valid_o, fifo_pop_o, wr_addr_o, ea[i]); end
      n_vec++; if (tile_done_o !== (i == 7) || op_done_o !== 1'b0) begin n_err++; $display("FAIL basic_done%0d: got tile=%b op=%b want %b 0", i, tile_done_o, op_done_o, i == 7); end
      @(negedge clk); #1;
    end
    n_vec++; if (op_done_o !== 1'b1 || busy_o !== 1'b1 || wr_valid_o !== 1'b0) begin n_err++; $display("FAIL basic_opdone: got op=%b busy=%b v=%b want 1 1 0", op_done_o, busy_o, wr_valid_o); end
    @(negedge clk); #1;
    n_vec++; if (op_done_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL basic_idle: got op=%b busy=%b want 0 0", op_done_o, busy_o); end
  endtask

  task automatic test_backpressure;
    int beat = 0, held = 0, stall = 0, pops = 0, cyc = 0;
    build_exp(4, 32, 32, 32'h1000);
    fifo_empty_i = 0; wr_ready_i = 1;
    start_op(4, 32, 32, 32'h1000);
    while (beat < 8 && cyc < 40) begin
      @(negedge clk); start_i = 0;
      wr_ready_i = !(beat == 2 && stall < 3);
      #1;
      if (beat == 2) begin held++; if (!wr_ready_i) stall++; end
      n_vec++; if (wr_valid_o !== 1'b1 || wr_addr_o !== exp_q[beat].addr) begin n_err++; $display("FAIL bp_beat%0d: got v=%b addr=%h want 1 %h", beat, wr_valid_o, wr_addr_o, exp_q[beat].addr); end
      n_vec++; if (fifo_pop_o !== wr_ready_i) begin n_err++; $display("FAIL bp_pop%0d: got %b want %b", beat, fifo_pop_o, wr_ready_i); end
      if (fifo_pop_o) pops++;
      if (wr_ready_i) beat++;
      cyc++;
    end
    n_vec++; if (held !== 4 || pops !== 8) begin n_err++; $display("FAIL bp_counts: got held=%0d pops=%0d want 4 8", held, pops); end
    @(negedge clk); #1;
    n_vec++; if (op_done_o !== 1'b1) begin n_err++; $display("FAIL bp_opdone: got %b want 1", op_done_o); end
  endtask

  task automatic test_zero;
    fifo_empty_i = 0; wr_ready_i = 1;
    start_op(0, 32, 32, 32'h3000);
    @(negedge clk); start_i = 0; #1;
    n_vec++; if (op_done_o !== 1'b1 || wr_valid_o !== 1'b0 || fifo_pop_o !== 1'b0) begin n_err++; $display("FAIL zero_done: got op=%b v=%b pop=%b want 1 0 0", op_done_o, wr_valid_o, fifo_pop_o); end
    @(negedge clk); #1;
    n_vec++; if (op_done_o !== 1'b0 || busy_o !== 1'b0 || fifo_pop_o !== 1'b0) begin n_err++; $display("FAIL zero_idle: got op=%b busy=%b pop=%b want 0 0 0", op_done_o, busy_o, fifo_pop_o); end
  endtask

  task automatic test_abort;
    bit saw_done = 0;
    build_exp(4, 32, 32, 32'h2000);
    fifo_empty_i = 0; wr_ready_i = 1;
    start_op(4, 32, 32, 32'h2000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); start_i = 0; #1;
      n_vec++; if (fifo_pop_o !== 1'b1 || wr_addr_o !== exp_q[i].addr) begin n_err++; $display("FAIL abort_pre%0d: got pop=%b addr=%h want 1 %h", i, fifo_pop_o, wr_addr_o, exp_q[i].addr); end
    end
    @(negedge clk); abort_i = 1; start_i = 1; #1;
    n_vec++; if (wr_valid_o !== 1'b0 || fifo_pop_o !== 1'b0) begin n_err++; $display("FAIL abort_gate: got v=%b pop=%b want 0 0", wr_valid_o, fifo_pop_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); abort_i = 0; start_i = 0; #1;
      if (op_done_o || busy_o || wr_valid_o) saw_done = 1;
    end
    n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_idle: got activity=%b want 0", saw_done); end
    start_op(4, 32, 32, 32'h2000);
    @(negedge clk); start_i = 0; #1;
    n_vec++; if (wr_valid_o !== 1'b1 || wr_addr_o !== 32'h2000) begin n_err++; $display("FAIL abort_restart: got v=%b addr=%h want 1 00002000", wr_valid_o, wr_addr_o); end
    @(negedge clk); abort_i = 1; #1;
    @(negedge clk); abort_i = 0; #1;
  endtask

`ifdef CFG_EDGE_MASK_EN
  task automatic test_edge;
    int pops = 0, writes = 0, disc = 0, cyc = 0;
    bit seen = 0;
    fifo_empty_i = 0; wr_ready_i = 1;
    start_op(6, 40, 40, 32'h0);
    @(negedge clk); start_i = 0; #1;
    while (!op_done_o && cyc < 200) begin
      if (fifo_pop_o) pops++;
      if (wr_valid_o && wr_ready_i) writes++;
      if (fifo_pop_o && !wr_valid_o) disc++;
      if (wr_valid_o && wr_addr_o == 32'h40) begin
        seen = 1;
        n_vec++; if (wr_strb_o !== 32'h0000FFFF) begin n_err++; $display("FAIL edge_strb: got %h want 0000ffff", wr_strb_o); end
      end
      @(negedge clk); #1; cyc++;
    end
    n_vec++; if (pops !== 32 || writes !== 18 || disc !== 14 || !seen) begin n_err++; $display("FAIL edge_counts: got pops=%0d wr=%0d disc=%0d seen=%b want 32 18 14 1", pops, writes, disc, seen); end
  endtask
`else
  task automatic test_cfg_err;
    fifo_empty_i = 0; wr_ready_i = 1;
    start_op(6, 32, 32, 32'h0);
    n_vec++; if (fifo_pop_o !== 1'b0) begin n_err++; $display("FAIL cfg_nopop: got %b want 0", fifo_pop_o); end
    @(negedge clk); start_i = 0; #1;
    n_vec++; if (cfg_err_o !== 1'b1 || busy_o !== 1'b0 || fifo_pop_o !== 1'b0) begin n_err++; $display("FAIL cfg_err: got err=%b busy=%b pop=%b want 1 0 0", cfg_err_o, busy_o, fifo_pop_o); end
    @(negedge clk); #1;
    n_vec++; if (cfg_err_o !== 1'b0 || busy_o !== 1'b0) begin n_err++; $display("FAIL cfg_after: got err=%b busy=%b want 0 0", cfg_err_o, busy_o); end
    start_op(4, 40, 40, 32'h0);
    @(negedge clk); start_i = 0; #1;
    n_vec++; if (cfg_err_o !== 1'b1 || busy_o !== 1'b0) begin n_err++; $display("FAIL cfg_err_p: got err=%b busy=%b want 1 0", cfg_err_o, busy_o); end
  endtask
`endif

  task automatic test_random;
    for (int op = 0; op < 12; op++) begin
      int m, p, ld, cyc;
      logic [31:0] base;
      bit ev, ep;
`ifdef CFG_EDGE_MASK_EN
      m = $urandom_range(1, 12); p = $urandom_range(1, 70);
`else
      m = 4 * $urandom_range(1, 3); p = 32 * $urandom_range(1, 2);
`endif
      ld = p + $urandom_range(0, 20);
      base = $urandom;
      build_exp(m, p, ld, base);
      start_op(m, p, ld, base);
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 2000) begin
        @(negedge clk);
        start_i = ($urandom_range(0, 7) == 0);
        m_i = 16'($urandom); p_i = 16'($urandom); base_addr_c_i = $urandom;
        fifo_empty_i = ($urandom_range(0, 3) == 0);
        wr_ready_i   = ($urandom_range(0, 3) != 0);
        #1;
        ev = exp_q[0].wr && !fifo_empty_i;
        ep = !fifo_empty_i && (exp_q[0].wr ? wr_ready_i : 1'b1);
        n_vec++; if (wr_valid_o !== ev || fifo_pop_o !== ep) begin n_err++; $display("FAIL rnd_hs op%0d: got v=%b pop=%b want %b %b", op, wr_valid_o, fifo_pop_o, ev, ep); end
        if (ev) begin
          n_vec++; if (wr_addr_o !== exp_q[0].addr || wr_strb_o !== exp_q[0].strb) begin n_err++; $display("FAIL rnd_data op%0d: got %h/%h want %h/%h", op, wr_addr_o, wr_strb_o, exp_q[0].addr, exp_q[0].strb); end
        end
        n_vec++; if (tile_done_o !== (ep && exp_q[0].tl) || op_done_o !== 1'b0) begin n_err++; $display("FAIL rnd_done op%0d: got tile=%b op=%b want %b 0", op, tile_done_o, op_done_o, ep && exp_q[0].tl); end
        if (ep) void'(exp_q.pop_front());
        cyc++;
      end
      n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_timeout op%0d: got %0d beats left want 0", op, exp_q.size()); end
      @(negedge clk); start_i = 0; #1;
      n_vec++; if (op_done_o !== 1'b1) begin n_err++; $display("FAIL rnd_opdone op%0d: got %b want 1", op, op_done_o); end
    end
  endtask

  task automatic test_reset_midrun;
    bit bad = 0;
    fifo_empty_i = 0; wr_ready_i = 1;
    start_op(8, 64, 64, 32'h4000);
    repeat (5) begin @(negedge clk); start_i = 0; end
    #2 reset_n = 0; #1;
    n_vec++; if (busy_o !== 1'b0 || wr_valid_o !== 1'b0 || wr_addr_o !== 32'h0) begin n_err++; $display("FAIL rst_async: got busy=%b v=%b addr=%h want 0 0 0", busy_o, wr_valid_o, wr_addr_o); end
    @(negedge clk); reset_n = 1;
    repeat (20) begin
      @(negedge clk); #1;
      if (op_done_o || busy_o || fifo_pop_o) bad = 1;
    end
    n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL rst_midrun: got activity=%b want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_zero;
    test_abort;
`ifdef CFG_EDGE_MASK_EN
    test_edge;
`else
    test_cfg_err;
`endif
    test_random;
    test_reset_midrun;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_c_tile_writer.md
MEM_C_TILE_WRITER -- requirements
Module: mem_c_tile_writer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
  BUS_WIDTH_BYTES   32  write bus width in bytes
  DATA_WIDTH_BYTES  2   element size in bytes, power of two
  ARRAY_HEIGHT      4   tile rows (H), power of two
  ARRAY_WIDTH       32  tile columns (W); W*DATA_WIDTH_BYTES is a multiple of BUS_WIDTH_BYTES
  ADDR_WIDTH        32  byte address width
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk            in   1    clock
  reset_n        in   1    reset, asynchronous, active-low
  start_i        in   1    start pulse; config sampled this cycle
  abort_i        in   1    cancel operation
  m_i            in   16   C rows
  p_i            in   16   C columns
  ld_c_i         in   16   C row pitch in elements
  base_addr_c_i  in   ADDR_WIDTH  C base byte address
  fifo_empty_i   in   1    result FIFO empty
  fifo_pop_o     out  1    consume one FIFO beat
  wr_valid_o     out  1    write request valid
  wr_ready_i     in   1    write request accepted
  wr_addr_o      out  ADDR_WIDTH  beat byte address
  wr_strb_o      out  BUS_WIDTH_BYTES  byte enables
  busy_o         out  1    operation in progress
  tile_done_o    out  1    one-cycle pulse, last beat of a tile consumed
  op_done_o      out  1    one-cycle pulse, operation complete
  cfg_err_o      out  1    one-cycle pulse, illegal config rejected

Function
REQ-003 EPB = BUS_WIDTH_BYTES/DATA_WIDTH_BYTES; BPR = W/EPB beats per tile row; H*BPR beats per tile.
REQ-004 Tile grid SHALL be ceil(m/H) x ceil(p/W); tiles visited row-major (tile column fastest); within a tile, row r fastest, then beat b.
REQ-005 Beat address SHALL be base + ((tr*H + r)*ld_c + tc*W + b*EPB)*DATA_WIDTH_BYTES, computed at 32 bits, truncated to ADDR_WIDTH.
REQ-006 FSM states IDLE, RUN, DONE; IDLE->RUN on start_i with legal config and m,p nonzero; IDLE->DONE on start_i with m==0 or p==0; RUN->DONE when last beat consumed; DONE->IDLE unconditionally.
REQ-007 op_done_o SHALL be high exactly in DONE; busy_o high in RUN and DONE.
REQ-008 In RUN, in-range beat: wr_valid_o = ~fifo_empty_i; fifo_pop_o = wr_valid_o & wr_ready_i; beat advances on pop.
REQ-009 wr_addr_o and wr_strb_o SHALL be registered and stable while wr_valid_o & ~wr_ready_i.
REQ-010 Out-of-range beat (row >= m, or first column >= p): wr_valid_o=0, fifo_pop_o = ~fifo_empty_i, beat advances (discard).
REQ-011 Throughput SHALL be one beat per cycle with FIFO non-empty and wr_ready_i high; first wr_valid_o at the cycle after start_i.
REQ-012 tile_done_o SHALL pulse in the cycle the last beat of each tile is popped.
REQ-013 start_i while busy_o SHALL be ignored.
REQ-014 abort_i SHALL force IDLE next cycle from any state, clear all counters, drop wr_valid_o and fifo_pop_o, suppress op_done_o; abort_i has priority over start_i.

Reset
REQ-015 On reset_n low: state IDLE, counters 0, all outputs 0 (wr_addr_o=0, wr_strb_o=0).
REQ-016 Reset mid-RUN SHALL abandon the operation with no op_done_o after release.

Configuration
REQ-017 CFG_EDGE_MASK_EN defined: partial edge tiles supported; wr_strb_o enables bytes only for columns < p; other in-range beats all ones.
REQ-018 CFG_EDGE_MASK_EN undefined: m must be a multiple of H and p of W; otherwise start_i yields cfg_err_o pulse next cycle, stays IDLE, no pops; wr_strb_o always all ones.

Verification (defaults: EPB=16, BPR=2, 8 beats/tile)
REQ-019 m=4,p=32,ld=32,base=0x1000, FIFO full, ready=1 -> 8 consecutive writes 0x1000,0x1040,0x1080,0x10C0,0x1020,0x1060,0x10A0,0x10E0; tile_done_o and op_done_o pulses next cycle.
REQ-020 Same, wr_ready_i low 3 cycles on beat 2 -> 0x1080 held valid 4 cycles, no pop until accept, total 8 pops.
REQ-021 CFG_EDGE_MASK_EN, m=6,p=40,ld=40,base=0 -> 32 pops, 18 writes, 14 discards; tile(0,1) beat0 strb 0x0000FFFF at 0x40.
REQ-022 m=0,p=32 start -> op_done_o next cycle, no valid, no pop.
REQ-023 abort_i after 3 accepts -> IDLE next cycle, no op_done_o; restart writes first beat at base.
REQ-024 Macro undefined, m=6 -> cfg_err_o pulse, busy_o stays 0.
